// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around a 512x32 data memory; define MEM_ALIGN_CHECK_EN for sticky misaligned-access detection
module mem_stage (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Stall,
  input  logic        RegWrite_E,
  input  logic        MemtoReg_E,
  input  logic        MemWrite_E,
  input  logic [31:0] ALUOut_E,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WriteReg_E,
  output logic        RegWrite_M,
  output logic [4:0]  WriteReg_M,
  output logic [31:0] ALUOut_M,
  output logic        RegWrite_W,
  output logic        MemtoReg_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] ALUOut_W,
  output logic [4:0]  WriteReg_W
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        Misalign
`endif
);
  logic        regwrite_m_q, regwrite_m_d, memtoreg_m_q, memtoreg_m_d, memwrite_m_q, memwrite_m_d;
  logic [31:0] aluout_m_q, aluout_m_d, writedata_m_q, writedata_m_d;
  logic [4:0]  writereg_m_q, writereg_m_d;
  logic        regwrite_w_q, regwrite_w_d, memtoreg_w_q, memtoreg_w_d;
  logic [31:0] readdata_w_q, readdata_w_d, aluout_w_q, aluout_w_d;
  logic [4:0]  writereg_w_q, writereg_w_d;
  logic [31:0] mem_q [512];
  logic [31:0] mem_d [512];
  logic        in_range, misaligned, we;
  logic [8:0]  word;
  logic [31:0] rdata;
  assign in_range = ~|aluout_m_q[31:11];
  assign word     = aluout_m_q[10:2];
  assign rdata    = in_range ? mem_q[word] : '0;
  assign we       = memwrite_m_q & ~Stall & in_range & ~misaligned;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misaligned = (memtoreg_m_q | memwrite_m_q) & |aluout_m_q[1:0] & ~Stall;
  assign misalign_d = misalign_q | misaligned;
  assign Misalign   = misalign_q;
  // sticky flag: once a misaligned access is seen it stays until reset
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
`else
  assign misaligned = 1'b0;
`endif
  // next pipeline contents: hold everything while stalled, otherwise advance one stage
  always_comb begin
    regwrite_m_d  = Stall ? regwrite_m_q  : RegWrite_E;
    memtoreg_m_d  = Stall ? memtoreg_m_q  : MemtoReg_E;
    memwrite_m_d  = Stall ? memwrite_m_q  : MemWrite_E;
    aluout_m_d    = Stall ? aluout_m_q    : ALUOut_E;
    writedata_m_d = Stall ? writedata_m_q : WriteData_E;
    writereg_m_d  = Stall ? writereg_m_q  : WriteReg_E;
    regwrite_w_d  = Stall ? regwrite_w_q  : regwrite_m_q & ~(misaligned & memtoreg_m_q);
    memtoreg_w_d  = Stall ? memtoreg_w_q  : memtoreg_m_q;
    readdata_w_d  = Stall ? readdata_w_q  : rdata;
    aluout_w_d    = Stall ? aluout_w_q    : aluout_m_q;
    writereg_w_d  = Stall ? writereg_w_q  : writereg_m_q;
  end
  // pipeline registers; reset clears every field immediately
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      regwrite_m_q  <= 1'b0;
      memtoreg_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      aluout_m_q    <= '0;
      writedata_m_q <= '0;
      writereg_m_q  <= '0;
      regwrite_w_q  <= 1'b0;
      memtoreg_w_q  <= 1'b0;
      readdata_w_q  <= '0;
      aluout_w_q    <= '0;
      writereg_w_q  <= '0;
    end else begin
      regwrite_m_q  <= regwrite_m_d;
      memtoreg_m_q  <= memtoreg_m_d;
      memwrite_m_q  <= memwrite_m_d;
      aluout_m_q    <= aluout_m_d;
      writedata_m_q <= writedata_m_d;
      writereg_m_q  <= writereg_m_d;
      regwrite_w_q  <= regwrite_w_d;
      memtoreg_w_q  <= memtoreg_w_d;
      readdata_w_q  <= readdata_w_d;
      aluout_w_q    <= aluout_w_d;
      writereg_w_q  <= writereg_w_d;
    end
  // memory update: only the addressed word changes, and only on a qualified store
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[word] = writedata_m_q;
  end
  // data memory; reset wipes all words so an in-flight store cannot survive
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign RegWrite_M = regwrite_m_q;
  assign WriteReg_M = writereg_m_q;
  assign ALUOut_M   = aluout_m_q;
  assign RegWrite_W = regwrite_w_q;
  assign MemtoReg_W = memtoreg_w_q;
  assign ReadData_W = readdata_w_q;
  assign ALUOut_W   = aluout_w_q;
  assign WriteReg_W = writereg_w_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, stall/reset sequences and randomized checking against a reference model
module tb_mem_stage;
  logic        CLOCK = 1'b0, RESET = 1'b1, Stall = 1'b0;
  logic        RegWrite_E = 1'b0, MemtoReg_E = 1'b0, MemWrite_E = 1'b0;
  logic [31:0] ALUOut_E = '0, WriteData_E = '0;
  logic [4:0]  WriteReg_E = '0;
  logic        RegWrite_M, RegWrite_W, MemtoReg_W;
  logic [4:0]  WriteReg_M, WriteReg_W;
  logic [31:0] ALUOut_M, ReadData_W, ALUOut_W;
`ifdef MEM_ALIGN_CHECK_EN
  logic        Misalign;
`endif

  mem_stage dut (
    .CLOCK(CLOCK), .RESET(RESET), .Stall(Stall),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
    .ALUOut_E(ALUOut_E), .WriteData_E(WriteData_E), .WriteReg_E(WriteReg_E),
    .RegWrite_M(RegWrite_M), .WriteReg_M(WriteReg_M), .ALUOut_M(ALUOut_M),
    .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .ReadData_W(ReadData_W),
    .ALUOut_W(ALUOut_W), .WriteReg_W(WriteReg_W)
`ifdef MEM_ALIGN_CHECK_EN
    , .Misalign(Misalign)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: an instruction record per stage and a plain word array
  typedef struct {logic rw, mtr, mw; logic [31:0] alu, wd; logic [4:0] wr;} instr_t;
  typedef struct {logic rw, mtr; logic [31:0] rd, alu; logic [4:0] wr;} wb_t;
  instr_t m_m;
  wb_t    m_w;
  logic [31:0] m_mem [512];
  bit     m_mis;

  task automatic model_reset;
    m_m = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0};
    m_w = '{1'b0, 1'b0, 32'h0, 32'h0, 5'h0};
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    m_mis = 0;
  endtask

  task automatic model_step;
    logic [31:0] rd;
    bit ok, mis;
    if (Stall) return;
    ok  = m_m.alu < 32'h800;
    rd  = ok ? m_mem[m_m.alu / 4] : 32'h0;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (m_m.mtr || m_m.mw) && (m_m.alu % 4 != 0);
    if (mis) m_mis = 1;
`endif
    if (m_m.mw && ok && !mis) m_mem[m_m.alu / 4] = m_m.wd;
    m_w = '{m_m.rw && !(mis && m_m.mtr), m_m.mtr, rd, m_m.alu, m_m.wr};
    m_m = '{RegWrite_E, MemtoReg_E, MemWrite_E, ALUOut_E, WriteData_E, WriteReg_E};
  endtask

  task automatic drive(input logic st, rw, mtr, mw, input logic [31:0] alu, wd, input logic [4:0] wr);
    Stall = st; RegWrite_E = rw; MemtoReg_E = mtr; MemWrite_E = mw;
    ALUOut_E = alu; WriteData_E = wd; WriteReg_E = wr;
  endtask

  task automatic tick;
    model_step();
    @(posedge CLOCK);
    #1;
  endtask

  typedef struct {
    logic rw, mtr, mw; logic [31:0] alu, wd; logic [4:0] wr;
    logic [31:0] e_alu_m, e_rd_w, e_alu_w; logic e_rw_w, e_mtr_w; logic [4:0] e_wr_w;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 1_000_000);
    $fatal(1);
  end

  initial begin
    model_reset();
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 5'd0,  32'h10,   32'h0,        32'h0,    1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h10,   32'h0,        5'd8,  32'h10,   32'h0,        32'h10,   1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h1234, 32'h0,        5'd3,  32'h1234, 32'hDEADBEEF, 32'h10,   1'b1, 1'b1, 5'd8};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        5'd0,  32'h0,    32'h0,        32'h1234, 1'b1, 1'b0, 5'd3};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h800,  32'h5,        5'd0,  32'h800,  32'h0,        32'h0,    1'b0, 1'b0, 5'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,    32'h0,        5'd9,  32'h0,    32'h0,        32'h800,  1'b0, 1'b0, 5'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h800,  32'h0,        5'd10, 32'h800,  32'h0,        32'h0,    1'b1, 1'b1, 5'd9};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h14,   32'hCAFEF00D, 5'd0,  32'h14,   32'h0,        32'h800,  1'b1, 1'b1, 5'd10};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h14,   32'h0,        5'd4,  32'h14,   32'h0,        32'h14,   1'b0, 1'b0, 5'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        5'd0,  32'h0,    32'hCAFEF00D, 32'h14,   1'b1, 1'b1, 5'd4};

    // reset held across edges with busy inputs
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h99, 5'd7);
    @(posedge CLOCK); @(posedge CLOCK); #1;
    chk("rst ALUOut_M", ALUOut_M, 32'h0);
    chk("rst RegWrite_M", RegWrite_M, 32'h0);
    chk("rst WriteReg_M", WriteReg_M, 32'h0);
    chk("rst ALUOut_W", ALUOut_W, 32'h0);
    chk("rst ReadData_W", ReadData_W, 32'h0);
    chk("rst RegWrite_W", RegWrite_W, 32'h0);
    chk("rst MemtoReg_W", MemtoReg_W, 32'h0);
    chk("rst WriteReg_W", WriteReg_W, 32'h0);
    RESET = 1'b0;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, tbl[i].rw, tbl[i].mtr, tbl[i].mw, tbl[i].alu, tbl[i].wd, tbl[i].wr);
      tick();
      chk($sformatf("vec%0d ALUOut_M", i), ALUOut_M, tbl[i].e_alu_m);
      chk($sformatf("vec%0d ReadData_W", i), ReadData_W, tbl[i].e_rd_w);
      chk($sformatf("vec%0d ALUOut_W", i), ALUOut_W, tbl[i].e_alu_w);
      chk($sformatf("vec%0d RegWrite_W", i), RegWrite_W, tbl[i].e_rw_w);
      chk($sformatf("vec%0d MemtoReg_W", i), MemtoReg_W, tbl[i].e_mtr_w);
      chk($sformatf("vec%0d WriteReg_W", i), WriteReg_W, tbl[i].e_wr_w);
    end

    // store held in M across a three-cycle stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h11112222, 5'd0);
    tick();
    chk("stall entry ALUOut_M", ALUOut_M, 32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40 + i * 4, 32'hBAD0 + i, 5'd7);
      tick();
      chk("stall ALUOut_M", ALUOut_M, 32'h20);
      chk("stall RegWrite_M", RegWrite_M, 32'h0);
      chk("stall WriteReg_M", WriteReg_M, 32'h0);
      chk("stall ALUOut_W", ALUOut_W, 32'h0);
      chk("stall RegWrite_W", RegWrite_W, 32'h0);
      chk("stall ReadData_W", ReadData_W, 32'h0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd12);
    tick();
    chk("release sw ALUOut_W", ALUOut_W, 32'h20);
    chk("release no early write", ReadData_W, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("release lw ReadData_W", ReadData_W, 32'h11112222);
    chk("release lw WriteReg_W", WriteReg_W, 32'h12 - 32'h6);

    // asynchronous reset between edges, with a store pending in M
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, 5'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h5A5A0008, 5'd0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 5'd5); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h99, 5'd0); tick();
    chk("pre-reset lw ReadData_W", ReadData_W, 32'hA5A5A5A5);
    chk("pre-reset ALUOut_M", ALUOut_M, 32'h8);
    #2 RESET = 1'b1;
    #1;
    chk("async rst ALUOut_M", ALUOut_M, 32'h0);
    chk("async rst ALUOut_W", ALUOut_W, 32'h0);
    chk("async rst ReadData_W", ReadData_W, 32'h0);
    chk("async rst RegWrite_W", RegWrite_W, 32'h0);
    chk("async rst WriteReg_W", WriteReg_W, 32'h0);
    #1 RESET = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 5'd5); tick();
    chk("first capture ALUOut_M", ALUOut_M, 32'h4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd6); tick();
    chk("post-rst lw 0x4", ReadData_W, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); tick();
    chk("post-rst lw 0x8", ReadData_W, 32'h0);
    chk("post-rst WriteReg_W", WriteReg_W, 32'h6);

`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h1234ABCD, 5'd0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h6, 32'hFFFF, 5'd0); tick();
    chk("pre misalign flag", Misalign, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 5'd7); tick();
    chk("misalign set", Misalign, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); tick();
    chk("misaligned sw suppressed", ReadData_W, 32'h1234ABCD);
    chk("aligned lw RegWrite_W", RegWrite_W, 32'h1);
    chk("misalign sticky", Misalign, 32'h1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 5'd9); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); tick();
    chk("misaligned lw RegWrite_W", RegWrite_W, 32'h0);
`endif

    // randomized run against the reference model
    RESET = 1'b1;
    #2;
    model_reset();
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom_range(0, 15) << 2) | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
      drive(1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
      tick();
      chk("rnd RegWrite_M", RegWrite_M, m_m.rw);
      chk("rnd WriteReg_M", WriteReg_M, m_m.wr);
      chk("rnd ALUOut_M", ALUOut_M, m_m.alu);
      chk("rnd RegWrite_W", RegWrite_W, m_w.rw);
      chk("rnd MemtoReg_W", MemtoReg_W, m_w.mtr);
      chk("rnd ReadData_W", ReadData_W, m_w.rd);
      chk("rnd ALUOut_W", ALUOut_W, m_w.alu);
      chk("rnd WriteReg_W", WriteReg_W, m_w.wr);
`ifdef MEM_ALIGN_CHECK_EN
      chk("rnd Misalign", Misalign, 32'(m_mis));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these ports, one per line, as name  direction  width  meaning; clock and reset come first.
REQ-002 CLOCK  in  1  the single clock for the block; all state changes on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 Stall  in  1  hold request from the hazard unit.
REQ-005 RegWrite_E, MemtoReg_E, MemWrite_E  in  1 each  control bits from the execute stage.
REQ-006 ALUOut_E  in  32  ALU result; this is the byte address for lw/sw.
REQ-007 WriteData_E  in  32  forwarded rt value, used as sw data.
REQ-008 WriteReg_E  in  5  destination register, already selected between rt and rd.
REQ-009 RegWrite_M  out  1;  WriteReg_M  out  5;  ALUOut_M  out  32  EX/MEM register contents, also used as the forwarding source.
REQ-010 RegWrite_W, MemtoReg_W  out  1 each;  ReadData_W, ALUOut_W  out  32 each;  WriteReg_W  out  5  MEM/WB register contents.
REQ-011 Misalign  out  1  sticky misaligned-access flag; present only when MEM_ALIGN_CHECK_EN is defined.

Function
REQ-012 The EX/MEM register SHALL capture all *_E inputs on every rising CLOCK edge while Stall=0, giving 1-cycle latency from E to M.
REQ-013 The MEM/WB register SHALL capture the M-stage values on every rising edge while Stall=0, giving 1-cycle latency from M to W.
REQ-014 Stall=1 SHALL hold both pipeline registers and suppress any memory write in that cycle.
REQ-015 The data memory SHALL be 512 x 32 bits, indexed by word index ALUOut_M[10:2].
REQ-016 Memory write SHALL occur at a rising edge when MemWrite_M=1, Stall=0 and the address is in range.
REQ-017 Memory read SHALL be combinational from the current memory contents at ALUOut_M; ReadData_W SHALL latch that value.
REQ-018 An address is out of range when ALUOut_M[31:11]!=0; such accesses SHALL suppress the write, and reads SHALL return 0.
REQ-019 For sw at cycle n followed by lw to the same address at cycle n+1 in M, the lw SHALL read the newly stored value.
REQ-020 Write-data forwarding and bubble insertion are upstream responsibilities; this block SHALL perform no hazard detection.
REQ-021 ReadData_W SHALL be registered for every instruction; the WB mux selects between ReadData_W and ALUOut_W using MemtoReg_W.

Reset
REQ-022 RESET=1 SHALL immediately clear all EX/MEM and MEM/WB fields to 0, independent of CLOCK.
REQ-023 RESET=1 SHALL clear all 512 memory words to 0, and SHALL clear Misalign when present.
REQ-024 A RESET asserted mid-store SHALL leave the targeted word at 0; no partial write may survive.
REQ-025 The first capture after RESET deasserts SHALL occur on the next rising edge with Stall=0.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined, a lw or sw in M with ALUOut_M[1:0]!=0 and Stall=0 SHALL suppress the write.
REQ-027 With MEM_ALIGN_CHECK_EN defined, that misaligned lw SHALL force RegWrite_W=0 in the next cycle.
REQ-028 With MEM_ALIGN_CHECK_EN defined, that misaligned access SHALL set Misalign=1, which holds until RESET.
REQ-029 Without MEM_ALIGN_CHECK_EN, the Misalign port SHALL be absent, ALUOut_M[1:0] SHALL be ignored, and the access SHALL proceed to word ALUOut_M[10:2].

Verification
REQ-030 Scenario: sw with ALUOut_E=0x10 and WriteData_E=0xDEADBEEF, then lw from 0x10 into $8 on the next cycle -> ReadData_W=0xDEADBEEF, WriteReg_W=8, MemtoReg_W=1 two cycles after the lw enters.
REQ-031 Scenario: R-type with ALUOut_E=0x1234 and WriteReg_E=3 -> ALUOut_M=0x1234 after 1 edge; ALUOut_W=0x1234, RegWrite_W=1 after 2 edges; no memory change.
REQ-032 Scenario: sw to 0x20 with Stall=1 held for 3 cycles, then released -> word 8 is unchanged during the stall, all M/W outputs are frozen, and the write lands on the first edge with Stall=0.
REQ-033 Scenario: sw to 0x00000800 (out of range) with data 0x5, then lw from 0x0 -> ReadData_W=0; lw from 0x800 -> ReadData_W=0.
REQ-034 Scenario: RESET pulsed between two clock edges after stores to 0x4 and 0x8 -> outputs go to 0 without a clock edge; subsequent lw from 0x4 -> 0.
REQ-035 Scenario (MEM_ALIGN_CHECK_EN defined): sw to 0x6 -> no write to word 1, and Misalign=1 after the edge; a following aligned lw has Misalign still 1 and RegWrite_W unaffected.
